// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter.
// Optional feature macro used by this slice: UART_TX_STOP2_EN (two stop bits).
package uart_tx_pkg;

    // Frame-level FSM states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Selects which source drives the serial line on the next edge
    typedef enum logic [1:0] {
        START_BIT,
        DATA_BIT,
        PAR_BIT,
        STOP_BIT
    } bit_sel_t;

    // Line levels for the framing bits; idle shares the stop level
    localparam logic START_BIT_VAL = 1'b0;
    localparam logic STOP_BIT_VAL  = 1'b1;

    // Width of a counter able to index every data bit (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data path of the UART transmitter: holds the accepted word, walks a bit
// index across it LSB first and derives the parity bit from the held word.
// The frame FSM in uart_tx_top drives load/enable and watches done.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] word,
    input  logic                 par_typ,
    output logic                 serial_bit,
    output logic                 done,
    output logic                 parity
);

    localparam int unsigned CNT_W = cnt_width(DATA_SIZE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_SIZE - 1);

    logic [DATA_SIZE-1:0] data_reg;
    logic [CNT_W-1:0]     count;
    logic                 typ_reg;

    // Capture the word and parity type on accept; advance the bit index while shifting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            typ_reg  <= 1'b0;
            count    <= '0;
        end else if (load) begin
            data_reg <= word;
            typ_reg  <= par_typ;
            count    <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Current data bit, last-bit flag and parity of the held word
    always_comb begin
        serial_bit = data_reg[count];
        done       = (count == LAST);
        parity     = (^data_reg) ^ typ_reg;
    end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter top: frame FSM plus registered output mux.
// One bit per clock: start (0), DATA_SIZE_top data bits LSB first,
// optional parity bit, stop bit (1). Outputs lag the FSM state by one clock.
// Optional feature macro: UART_TX_STOP2_EN -- when defined the stop bit
// lasts two clocks and Busy_top covers both.
module uart_tx_top
    import uart_tx_pkg::*;
#(
    parameter int DATA_SIZE_top = 8
) (
    input  logic                     CLK_top,
    input  logic                     RST_top,
    input  logic [DATA_SIZE_top-1:0] P_DATA_top,
    input  logic                     Data_Valid_top,
    input  logic                     PAR_EN_top,
    input  logic                     PAR_TYP_top,
    output logic                     TX_OUT_top,
    output logic                     Busy_top
);

    state_t   state;
    bit_sel_t sel;
    logic     par_en_reg;
    logic     accept;
    logic     shift;
    logic     serial_bit;
    logic     data_done;
    logic     par_bit;
    logic     line_bit;
`ifdef UART_TX_STOP2_EN
    logic     stop_second;
`endif

    // Data path: word register, bit index and parity
    uart_tx_serializer #(
        .DATA_SIZE (DATA_SIZE_top)
    ) u_serializer (
        .clk        (CLK_top),
        .rst_n      (RST_top),
        .load       (accept),
        .enable     (shift),
        .word       (P_DATA_top),
        .par_typ    (PAR_TYP_top),
        .serial_bit (serial_bit),
        .done       (data_done),
        .parity     (par_bit)
    );

    // Strobes are only honoured in IDLE; the index advances only in DATA
    always_comb begin
        accept = (state == IDLE) && Data_Valid_top;
        shift  = (state == DATA);
    end

    // Map the current state to the source of the next line bit
    always_comb begin
        unique case (state)
            START:   sel = START_BIT;
            DATA:    sel = DATA_BIT;
            PARITY:  sel = PAR_BIT;
            default: sel = STOP_BIT;
        endcase
    end

    // Output mux; idle shares the stop level so the line rests high
    always_comb begin
        unique case (sel)
            START_BIT: line_bit = START_BIT_VAL;
            DATA_BIT:  line_bit = serial_bit;
            PAR_BIT:   line_bit = par_bit;
            default:   line_bit = STOP_BIT_VAL;
        endcase
    end

    // Frame FSM with registered line and busy outputs
    always_ff @(posedge CLK_top or negedge RST_top) begin
        if (!RST_top) begin
            state      <= IDLE;
            par_en_reg <= 1'b0;
            TX_OUT_top <= STOP_BIT_VAL;
            Busy_top   <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_second <= 1'b0;
`endif
        end else begin
            TX_OUT_top <= line_bit;
            Busy_top   <= (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (Data_Valid_top) begin
                        par_en_reg <= PAR_EN_top;
                        state      <= START;
                    end
                end
                START: begin
                    state <= DATA;
                end
                DATA: begin
                    if (data_done) begin
                        state <= par_en_reg ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    state <= STOP;
                end
                STOP: begin
`ifdef UART_TX_STOP2_EN
                    // Stay one extra clock so the line carries two stop bits
                    if (stop_second) begin
                        stop_second <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        stop_second <= 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed self-checking bench for uart_tx_top (8-bit data).
// Honours UART_TX_STOP2_EN when the design is built with it.
module tb_uart_tx_top;

    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_LEN = 2;
`else
    localparam int STOP_LEN = 1;
`endif

    logic          CLK_top        = 1'b0;
    logic          RST_top        = 1'b1;
    logic [DW-1:0] P_DATA_top     = '0;
    logic          Data_Valid_top = 1'b0;
    logic          PAR_EN_top     = 1'b0;
    logic          PAR_TYP_top    = 1'b0;
    logic          TX_OUT_top;
    logic          Busy_top;

    int checks   = 0;
    int failures = 0;

    uart_tx_top #(
        .DATA_SIZE_top (DW)
    ) dut (
        .CLK_top        (CLK_top),
        .RST_top        (RST_top),
        .P_DATA_top     (P_DATA_top),
        .Data_Valid_top (Data_Valid_top),
        .PAR_EN_top     (PAR_EN_top),
        .PAR_TYP_top    (PAR_TYP_top),
        .TX_OUT_top     (TX_OUT_top),
        .Busy_top       (Busy_top)
    );

    always #5 CLK_top = ~CLK_top;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called on a falling edge: present a word and let the next rising edge accept it
    task automatic start(input logic [DW-1:0] d, input logic pen, input logic typ, input bit hold);
        P_DATA_top     = d;
        PAR_EN_top     = pen;
        PAR_TYP_top    = typ;
        Data_Valid_top = 1'b1;
        @(negedge CLK_top);
        if (!hold) Data_Valid_top = 1'b0;
    endtask

    // Called on the falling edge right after the accept edge. par is the hand-computed parity bit.
    task automatic run_frame(input string name, input logic [DW-1:0] d, input logic pen,
                             input logic par, input bit disturb, input bit chain,
                             input logic [DW-1:0] nd);
        int   nbits;
        logic e;
        nbits = 1 + DW + (pen ? 1 : 0) + STOP_LEN;
        check({name, "_pre_tx"}, TX_OUT_top, 1'b1);
        check({name, "_pre_busy"}, Busy_top, 1'b0);
        for (int j = 0; j < nbits; j++) begin
            @(negedge CLK_top);
            if (j == 0)                     e = 1'b0;
            else if (j <= DW)               e = d[j-1];
            else if (pen && (j == DW + 1))  e = par;
            else                            e = 1'b1;
            check($sformatf("%s_tx%0d", name, j), TX_OUT_top, e);
            check($sformatf("%s_busy%0d", name, j), Busy_top, 1'b1);
            if (disturb && (j >= 1) && (j <= 4)) begin
                P_DATA_top     = '0;
                PAR_EN_top     = 1'b0;
                PAR_TYP_top    = 1'b1;
                Data_Valid_top = 1'b1;
            end else begin
                Data_Valid_top = 1'b0;
            end
            if (chain && (j == nbits - 1)) begin
                P_DATA_top     = nd;
                PAR_EN_top     = 1'b0;
                PAR_TYP_top    = 1'b0;
                Data_Valid_top = 1'b1;
            end
        end
        @(negedge CLK_top);
        check({name, "_post_tx"}, TX_OUT_top, 1'b1);
        check({name, "_post_busy"}, Busy_top, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] rd;

        // Reset, then idle with no strobe
        #2 RST_top = 1'b0;
        @(negedge CLK_top);
        check("rst_tx", TX_OUT_top, 1'b1);
        check("rst_busy", Busy_top, 1'b0);
        RST_top = 1'b1;
        repeat (2) begin
            @(negedge CLK_top);
            check("idle_tx", TX_OUT_top, 1'b1);
            check("idle_busy", Busy_top, 1'b0);
        end

        // 8'b1001_1101 has five ones: odd parity bit 0, even parity bit 1
        start(8'b1001_1101, 1'b1, 1'b1, 1'b1);
        run_frame("odd", 8'b1001_1101, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        start(8'b1001_1101, 1'b1, 1'b0, 1'b0);
        run_frame("even", 8'b1001_1101, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        start(8'b1001_1101, 1'b0, 1'b0, 1'b0);
        run_frame("nopar", 8'b1001_1101, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // 8'hD3 has five ones: even parity bit 1 (live 8'h00 would give 0)
        start(8'hD3, 1'b1, 1'b0, 1'b0);
        run_frame("hold_in", 8'hD3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) begin
            @(negedge CLK_top);
            check("no_refire_tx", TX_OUT_top, 1'b1);
            check("no_refire_busy", Busy_top, 1'b0);
        end

        // Reset during data bit 3 of 8'h07 (bits 1,1,1,0,...)
        rd = 8'h07;
        start(rd, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            @(negedge CLK_top);
            check($sformatf("mid_tx%0d", j), TX_OUT_top, (j == 0) ? 1'b0 : rd[j-1]);
            check($sformatf("mid_busy%0d", j), Busy_top, 1'b1);
        end
        RST_top = 1'b0;
        #1;
        check("async_rst_tx", TX_OUT_top, 1'b1);
        check("async_rst_busy", Busy_top, 1'b0);
        @(negedge CLK_top);
        RST_top = 1'b1;
        @(negedge CLK_top);
        check("after_rst_tx", TX_OUT_top, 1'b1);
        check("after_rst_busy", Busy_top, 1'b0);

        // 8'h3C has four ones: odd parity bit 1; chained straight into 8'hA5 without parity
        start(8'h3C, 1'b1, 1'b1, 1'b0);
        run_frame("clean", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
        run_frame("b2b", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
